// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data-width select encoding,
// error-flag bit positions and the minimum supported divisor.
// No ports; imported by the UART RX/TX blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StParity   = 3'd3,
        StStop1    = 3'd4,
        StStop2    = 3'd5,
        StWaitHigh = 3'd6
    } rx_state_e;

    typedef enum logic [1:0] {
        DataBits5 = 2'b00,
        DataBits6 = 2'b01,
        DataBits7 = 2'b10,
        DataBits8 = 2'b11
    } data_bits_e;

    localparam int unsigned ErrPar = 0;
    localparam int unsigned ErrFrm = 1;
    localparam int unsigned ErrBrk = 2;
    localparam int unsigned ErrW   = 3;
    localparam int unsigned ByteW  = 8;
    localparam int unsigned MinDiv = 4;

    // Index of the last data bit: 5 bits -> 4 ... 8 bits -> 7.
    function automatic logic [2:0] last_bit_idx(data_bits_e sel);
        return {1'b1, sel};
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus-side receive FIFO interface of uart_rx_fifo.
//   slave  : the receiver (drives head data, flags, status)
//   master : the register block (drives i_Rd_En / i_Clr_Overrun)
interface uart_rx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 16
) ();
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic            i_Rd_En;
    logic            i_Clr_Overrun;
    logic [7:0]      o_Rx_Byte;
    logic [2:0]      o_Rx_Err;
    logic            o_Empty;
    logic            o_Full;
    logic [CntW-1:0] o_Count;
    logic            o_Rx_DV;
    logic            o_Overrun;

    modport slave (
        input  i_Rd_En, i_Clr_Overrun,
        output o_Rx_Byte, o_Rx_Err, o_Empty, o_Full, o_Count, o_Rx_DV, o_Overrun
    );

    modport master (
        output i_Rd_En, i_Clr_Overrun,
        input  o_Rx_Byte, o_Rx_Err, o_Empty, o_Full, o_Count, o_Rx_DV, o_Overrun
    );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO.
//   push_i/wdata_i : write; accepted when not full, or when full with pop_i
//   pop_i          : drop the head; ignored when empty
//   rdata_o        : head entry (valid while !empty_o)
//   full_o/empty_o/count_o : occupancy status
// Storage is not reset; only pointers and count are.
module sync_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_Clock,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    // A pop while full frees the slot the push lands in.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Configurable UART receiver (5-8 data bits, none/even/odd parity, 1/2 stop
// bits, runtime divisor) feeding a show-ahead FIFO with per-frame error flags.
//   i_Clock, rst             : clock, async active-high reset
//   i_Rx_Serial              : asynchronous serial line (idle high)
//   i_Div, i_ld_Cfg, i_Data_Bits, i_Parity_En, i_Parity_Odd, i_Two_Stop :
//                              shadow configuration, loaded on i_ld_Cfg
//   rx_bus                   : FIFO read side and status (uart_rx_fifo_if.slave)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 32
) (
    input  logic             i_Clock,
    input  logic             rst,
    input  logic             i_Rx_Serial,
    input  logic [DIV_W-1:0] i_Div,
    input  logic             i_ld_Cfg,
    input  logic [1:0]       i_Data_Bits,
    input  logic             i_Parity_En,
    input  logic             i_Parity_Odd,
    input  logic             i_Two_Stop,
    uart_rx_fifo_if.slave    rx_bus
);
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned EntryW = ByteW + ErrW;

    logic             rx_meta_q, rx_sync_q;
    logic [DIV_W-1:0] sh_div_q, act_div_q;
    data_bits_e       sh_bits_q, act_bits_q;
    logic             sh_par_en_q, sh_par_odd_q, sh_two_stop_q;
    logic             act_par_en_q, act_par_odd_q, act_two_stop_q;
    rx_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       data_q, data_d;
    logic             par_bit_q, par_bit_d, par_err_q, par_err_d, frm_q, frm_d;
    logic             rx_dv_q, overrun_q;
    logic             load_act, push, frm_now, at_end;
    logic [ErrW-1:0]  push_err;
    logic [EntryW-1:0] fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic [CntW-1:0]  fifo_count;
    logic             wr_ok, overrun_set;

    assign at_end = (cnt_q == act_div_q - DIV_W'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + DIV_W'(1);
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        par_bit_d = par_bit_q;
        par_err_d = par_err_q;
        frm_d     = frm_q;
        load_act  = 1'b0;
        push      = 1'b0;
        frm_now   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                data_d    = '0;
                par_bit_d = 1'b0;
                par_err_d = 1'b0;
                frm_d     = 1'b0;
                if (!rx_sync_q) begin
                    state_d  = StStart;
                    load_act = 1'b1;
                end
            end
            StStart: begin
                if (cnt_q == (act_div_q >> 1)) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? StIdle : StData;
                end
            end
            StData: begin
                if (at_end) begin
                    cnt_d             = '0;
                    data_d[bit_idx_q] = rx_sync_q;
                    bit_idx_d         = bit_idx_q + 3'd1;
                    if (bit_idx_q == last_bit_idx(act_bits_q)) begin
                        state_d = act_par_en_q ? StParity : StStop1;
                    end
                end
            end
            StParity: begin
                if (at_end) begin
                    cnt_d     = '0;
                    par_bit_d = rx_sync_q;
                    par_err_d = rx_sync_q ^ (^data_q) ^ act_par_odd_q;
                    state_d   = StStop1;
                end
            end
            StStop1: begin
                if (at_end) begin
                    cnt_d = '0;
                    if (act_two_stop_q) begin
                        frm_d   = ~rx_sync_q;
                        state_d = StStop2;
                    end else begin
                        frm_now = ~rx_sync_q;
                        push    = 1'b1;
                        state_d = StWaitHigh;
                    end
                end
            end
            StStop2: begin
                if (at_end) begin
                    cnt_d   = '0;
                    frm_now = frm_q | ~rx_sync_q;
                    push    = 1'b1;
                    state_d = StWaitHigh;
                end
            end
            StWaitHigh: begin
                // A held-low line (break) yields a single frame until it idles.
                cnt_d = '0;
                if (rx_sync_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        push_err         = '0;
        push_err[ErrPar] = par_err_q;
        push_err[ErrFrm] = frm_now;
        push_err[ErrBrk] = frm_now && (data_q == '0) && !par_bit_q;
    end

    assign wr_ok       = push && (!fifo_full || rx_bus.i_Rd_En);
    assign overrun_set = push && fifo_full && !rx_bus.i_Rd_En;

    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) begin
            rx_meta_q      <= 1'b1;
            rx_sync_q      <= 1'b1;
            sh_div_q       <= DIV_W'(MinDiv);
            sh_bits_q      <= DataBits8;
            sh_par_en_q    <= 1'b0;
            sh_par_odd_q   <= 1'b0;
            sh_two_stop_q  <= 1'b0;
            act_div_q      <= DIV_W'(MinDiv);
            act_bits_q     <= DataBits8;
            act_par_en_q   <= 1'b0;
            act_par_odd_q  <= 1'b0;
            act_two_stop_q <= 1'b0;
            state_q        <= StIdle;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            data_q         <= '0;
            par_bit_q      <= 1'b0;
            par_err_q      <= 1'b0;
            frm_q          <= 1'b0;
            rx_dv_q        <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            rx_meta_q <= i_Rx_Serial;
            rx_sync_q <= rx_meta_q;
            if (i_ld_Cfg) begin
                sh_div_q      <= (i_Div < DIV_W'(MinDiv)) ? DIV_W'(MinDiv) : i_Div;
                sh_bits_q     <= data_bits_e'(i_Data_Bits);
                sh_par_en_q   <= i_Parity_En;
                sh_par_odd_q  <= i_Parity_Odd;
                sh_two_stop_q <= i_Two_Stop;
            end
            // Freeze the format for the whole frame at start detection.
            if (load_act) begin
                act_div_q      <= sh_div_q;
                act_bits_q     <= sh_bits_q;
                act_par_en_q   <= sh_par_en_q;
                act_par_odd_q  <= sh_par_odd_q;
                act_two_stop_q <= sh_two_stop_q;
            end
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            par_bit_q <= par_bit_d;
            par_err_q <= par_err_d;
            frm_q     <= frm_d;
            rx_dv_q   <= wr_ok;
            // Set wins over a simultaneous clear.
            if (overrun_set)                 overrun_q <= 1'b1;
            else if (rx_bus.i_Clr_Overrun)   overrun_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({data_q, push_err}),
        .pop_i   (rx_bus.i_Rd_En),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Head is forced to zero when empty so unreset storage never shows.
    assign rx_bus.o_Rx_Byte = fifo_empty ? '0 : fifo_rdata[EntryW-1:ErrW];
    assign rx_bus.o_Rx_Err  = fifo_empty ? '0 : fifo_rdata[ErrW-1:0];
    assign rx_bus.o_Empty   = fifo_empty;
    assign rx_bus.o_Full    = fifo_full;
    assign rx_bus.o_Count   = fifo_count;
    assign rx_bus.o_Rx_DV   = rx_dv_q;
    assign rx_bus.o_Overrun = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver that supersedes the fixed 8N1 receiver in the MCU UART subsystem. It supports runtime-configurable divisor, data width (5–8 bits), parity (none, even or odd) and stop bits (1 or 2). Each received frame is pushed, with per-frame error flags, into an internal show-ahead FIFO that the bus-side UART register block drains.

## Interface
- FIFO_DEPTH, 16, entries in the receive FIFO; power of 2, ≥2
- DIV_W, 32, width of the clocks-per-bit divisor
- i_Clock  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_Rx_Serial  in  1  serial input, asynchronous to i_Clock, idles high
- i_Div  in  DIV_W  clocks per bit
- i_ld_Cfg  in  1  load i_Div and the frame-format inputs into the shadow registers
- i_Data_Bits  in  2  data width select: 00=5, 01=6, 10=7, 11=8
- i_Parity_En  in  1  parity bit present
- i_Parity_Odd  in  1  1=odd parity, 0=even parity
- i_Two_Stop  in  1  two stop bits
- i_Rd_En  in  1  pop the FIFO head
- i_Clr_Overrun  in  1  clear o_Overrun
- o_Rx_Byte  out  8  FIFO head data, zero-extended above the data width
- o_Rx_Err  out  3  FIFO head flags {break, framing, parity}
- o_Empty  out  1  FIFO empty
- o_Full  out  1  FIFO full
- o_Count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- o_Rx_DV  out  1  one-cycle pulse per frame written to the FIFO
- o_Overrun  out  1  sticky: a frame was dropped because the FIFO was full

## Operation
- **Input synchroniser:** i_Rx_Serial passes through a 2-flop synchroniser. Both flops reset to 1 (idle line).
- **Configuration:**
  - i_ld_Cfg is accepted in any state and updates the shadow registers.
  - The active configuration is copied from the shadow on the IDLE→START transition, so a frame in flight never changes format.
  - Effective divisor is max(i_Div, 4).
  - Shadow reset values: Div=4, 8 data bits, no parity, 1 stop bit.
- **FSM states:** IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
- **IDLE:** clear the bit counter and clock counter. Go to START when the synchronised line is 0.
- **START:** count clocks. At count == Div/2 (integer), sample the line:
  - 0 → clear the counter, go to DATA.
  - 1 → glitch, return to IDLE; nothing is pushed.
- **DATA:** sample at count == Div−1, then clear the counter. Bits are LSB first into bit index 0..N−1. After bit N−1, go to PARITY if parity is enabled, otherwise STOP1.
- **PARITY:** sample at Div−1. Parity error if sampled bit ≠ (XOR of data bits) ^ i_Parity_Odd.
- **STOP1 / STOP2:** sample at Div−1.
  - Framing error if any stop sample is 0.
  - STOP2 is entered only when two stop bits are configured.
- **Push:** the push happens in the cycle of the final stop sample. Frames with errors are still pushed.
- **Break flag:** set when the framing flag is set, all data bits are 0, and the parity bit (if present) is 0.
- **Return to idle:** after the push, go to WAIT_HIGH. Remain there until the synchronised line is 1, then go to IDLE. A break therefore produces exactly one frame.
- **FIFO push/pop rules:**
  - Push when full: frame dropped, o_Overrun set. A pop in the same cycle frees the slot, and the push then succeeds.
  - i_Rd_En when empty is ignored.
  - Simultaneous push and pop leaves o_Count unchanged.
- **Overrun:** a set event and i_Clr_Overrun in the same cycle → o_Overrun stays 1.
- **Reset mid-frame:** rst mid-frame aborts the frame, empties the FIFO and returns to IDLE.

## Timing
- **Reset values:** o_Rx_Byte=0, o_Rx_Err=0, o_Empty=1, o_Full=0, o_Count=0, o_Rx_DV=0, o_Overrun=0, FSM=IDLE.
- **Start detection:** the IDLE→START decision is made 2 cycles after the pin falls (synchroniser latency).
- **Bit centres:** data bit k is sampled Div/2 + 1 + (k+1)·Div cycles after START entry (±1 cycle).
- **Push to outputs:** o_Rx_DV, o_Empty deassert, o_Count increment and head data are all visible in the cycle after the push cycle.
- **FIFO head:** o_Rx_Byte/o_Rx_Err are show-ahead and valid whenever o_Empty=0. After i_Rd_En, the next entry appears in the following cycle.
- **Throughput:** one frame per frame time. The FIFO never stalls the receiver.

## Structure
- **Shared package (uart_pkg):**
  - state encodings
  - data-bits select encoding
  - Err bit positions: PAR=0, FRM=1, BRK=2
  - minimum divisor constant 4
- **Sub-module sync_fifo:** parameters WIDTH=11 and DEPTH; ports push/pop/full/empty/count. Its storage memory has no reset; only the pointers and count reset. The same sub-module is reusable for the TX side.
- **Top level:** contains the synchroniser, shadow/active configuration, FSM with counters, and the overrun flag.

## Test plan
- **8N1 baseline:** Div=8, send 0xA5 at 8 clocks/bit → one o_Rx_DV pulse; head 0xA5, Err=000, o_Count=1.
- **7E2 parity error:** Div=10, 7 data bits, even parity, two stop bits; send 0x55 with the parity bit wrong → head 0x55, Err=001. Then 0x2A with correct parity → Err=000.
- **Break:** hold the line low for 20 bit times → exactly one entry with data 0x00, Err=110. The next frame is received only after the line returns high.
- **Start glitch:** low pulse of Div/2−1 cycles → no push, FSM back in IDLE.
- **Overrun:** FIFO_DEPTH=4, send 5 frames without reads → o_Full=1, o_Overrun=1, entries 1–4 intact. Then pop-during-push at full → push accepted, o_Count stays 4.
- **Config timing:** i_ld_Cfg changing Div from 8 to 16 mid-frame → current frame decoded at Div=8, next frame at Div=16.
